flash_sample_sequencer: RTL

Controller that sequences audio playback out of the flash memory interface under keyboard control. It walks the flash word address forward or backward and issues Avalon-MM reads. It splits each 32-bit word into two 16-bit samples and presents one sample per `sample_tick`. It sits between the keyboard FSM outputs (`pause`, `reverse`, `restart`) and the flash controller/audio path.

---
 rtl/flash_sample_sequencer_if.sv | 30 +++
 rtl/flash_sample_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/flash_sample_sequencer_if.sv
// Avalon-MM read bundle between the sample sequencer and the flash controller.
// The sequencer is the master; the flash controller is the slave.
interface flash_sample_sequencer_if #(
  parameter int unsigned ADDR_W = 23
);
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [3:0]        flash_mem_byteenable;
  logic              flash_mem_waitrequest;
  logic              flash_mem_readdatavalid;
  logic [31:0]       flash_mem_readdata;

  modport master (
    output flash_mem_read,
    output flash_mem_address,
    output flash_mem_byteenable,
    input  flash_mem_waitrequest,
    input  flash_mem_readdatavalid,
    input  flash_mem_readdata
  );

  modport slave (
    input  flash_mem_read,
    input  flash_mem_address,
    input  flash_mem_byteenable,
    output flash_mem_waitrequest,
    output flash_mem_readdatavalid,
    output flash_mem_readdata
  );
endinterface

// File: rtl/flash_sample_sequencer.sv
// Walks flash word addresses and splits each 32-bit word into two
// 16-bit audio samples, one per sample tick, under keyboard control.
module flash_sample_sequencer #(
  parameter int unsigned       ADDR_W   = 23,
  parameter logic [ADDR_W-1:0] ADDR_MAX = 23'h7FFFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_tick,
  input  logic                     pause,
  input  logic                     reverse,
  input  logic                     restart,
  flash_sample_sequencer_if.master flash_mem,
  output logic [15:0]              audio_sample,
  output logic                     audio_valid,
  output logic                     underrun
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    HALF1,
    HALF2
  } state_e;

  localparam logic [ADDR_W-1:0] ONE = 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       buf_q, buf_d;
  logic              dir_q, dir_d;
  logic              pend_q, pend_d;
  logic [15:0]       smp_q, smp_d;
  logic              vld_q, vld_d;
  logic              und_q, und_d;

  logic              tick_ok;
  logic [ADDR_W-1:0] step_addr;
  logic [ADDR_W-1:0] rst_addr;

  assign tick_ok  = sample_tick & ~pause;
  assign rst_addr = reverse ? ADDR_MAX : '0;

  always_comb begin
    step_addr = addr_q + ONE;
    if (reverse) begin
      step_addr = (addr_q == '0) ? ADDR_MAX : addr_q - ONE;
    end else if (addr_q == ADDR_MAX) begin
      step_addr = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      buf_q   <= '0;
      dir_q   <= 1'b0;
      pend_q  <= 1'b0;
      smp_q   <= '0;
      vld_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      smp_q   <= smp_d;
      vld_q   <= vld_d;
      und_q   <= und_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (!flash_mem.flash_mem_waitrequest) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (flash_mem.flash_mem_readdatavalid) begin
          state_d = (pend_q | restart) ? REQ : HALF1;
        end
      end
      HALF1: begin
        if (restart)      state_d = REQ;
        else if (tick_ok) state_d = HALF2;
      end
      HALF2: begin
        if (restart | tick_ok) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    buf_d  = buf_q;
    dir_d  = dir_q;
    pend_d = pend_q;
    smp_d  = smp_q;
    vld_d  = 1'b0;
    und_d  = 1'b0;
    unique case (state_q)
      REQ: begin
        und_d = tick_ok;
        if (restart) pend_d = 1'b1;
      end
      WAIT_DATA: begin
        und_d = tick_ok;
        // a restart seen during the read discards the word it returns
        if (flash_mem.flash_mem_readdatavalid) begin
          if (pend_q | restart) begin
            addr_d = rst_addr;
            pend_d = 1'b0;
          end else begin
            buf_d = flash_mem.flash_mem_readdata;
            dir_d = reverse;
          end
        end else if (restart) begin
          pend_d = 1'b1;
        end
      end
      HALF1: begin
        if (restart) begin
          addr_d = rst_addr;
        end else if (tick_ok) begin
          smp_d = dir_q ? buf_q[31:16] : buf_q[15:0];
          vld_d = 1'b1;
        end
      end
      HALF2: begin
        if (restart) begin
          addr_d = rst_addr;
        end else if (tick_ok) begin
          smp_d  = dir_q ? buf_q[15:0] : buf_q[31:16];
          vld_d  = 1'b1;
          addr_d = step_addr;
        end
      end
      default: ;
    endcase
  end

  assign flash_mem.flash_mem_read       = (state_q == REQ);
  assign flash_mem.flash_mem_address    = addr_q;
  assign flash_mem.flash_mem_byteenable = 4'hF;

  assign audio_sample = smp_q;
  assign audio_valid  = vld_q;
  assign underrun     = und_q;

endmodule
